hazard_tracker: RTL and testbench

- Sits beside the decode stage of the 5-stage MIPS pipeline (D, E, M, W) and consumes the per-instruction control signals the controller produces.
- Keeps a registered scoreboard of in-flight register writers in E, M and W.
- Decides each cycle whether the instruction in D must stall.
- Reports, per source operand, which pipeline stage holds the newest value so the datapath can forward it.

---
 rtl/hazard_tracker.sv | 135 +++++++++++++
 tb/tb_hazard_tracker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// Decode-side hazard tracker: scoreboard of E/M/W register writers, stall decision and per-operand forwarding source.
// Latency: stall and d_fwd1/d_fwd2 are combinational from the scoreboard and the D inputs; the scoreboard advances every clock.
// Backpressure: stall=1 holds the instruction in D and pushes a bubble into E; upstream must hold its D inputs stable.
//
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   d_valid                           D holds a real instruction (0 = bubble)
//   d_read_id1/2, d_need_stage1/2     source registers and the stage each is consumed at (0 D, 1 E, 2 M, 3 none)
//   d_write_enabled, d_write_id       destination of the instruction in D
//   d_ready_stage                     last stage before the result exists (0 D, 1 E, 2 M, 3 same as 2)
//   stall                             hold PC and F/D, bubble into E
//   d_fwd1/2                          newest value source: 0 regfile, 1 E/M, 2 M/W, 3 W write-through
//   stall_count                       saturating count of stall cycles since reset
module hazard_tracker #(
    parameter int REG_ID_WIDTH      = 5,
    parameter int STALL_COUNT_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         d_valid,
    input  logic [REG_ID_WIDTH-1:0]      d_read_id1,
    input  logic [REG_ID_WIDTH-1:0]      d_read_id2,
    input  logic [1:0]                   d_need_stage1,
    input  logic [1:0]                   d_need_stage2,
    input  logic                         d_write_enabled,
    input  logic [REG_ID_WIDTH-1:0]      d_write_id,
    input  logic [1:0]                   d_ready_stage,
    output logic                         stall,
    output logic [1:0]                   d_fwd1,
    output logic [1:0]                   d_fwd2,
    output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

    localparam logic [1:0] NEED_NONE = 2'd3;

    // Scoreboard entries for the instructions in E, M and W.
    logic                    e_vld_q, m_vld_q, w_vld_q;
    logic [REG_ID_WIDTH-1:0] e_id_q,  m_id_q,  w_id_q;
    logic [1:0]              e_rdy_q, m_rdy_q, w_rdy_q;
    logic                    e_vld_d;
    logic [REG_ID_WIDTH-1:0] e_id_d;
    logic [1:0]              e_rdy_d;

    logic [STALL_COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic       d_ent_vld;
    logic [1:0] d_rdy_norm;
    logic [1:0] rdy1, rdy2;
    logic       hz1, hz2;

    // Nearest producer of rid: 1 = E, 2 = M, 3 = W, 0 = none. $0 never matches.
    function automatic logic [1:0] src_stage(
        input logic [REG_ID_WIDTH-1:0] rid,
        input logic                    ev, input logic [REG_ID_WIDTH-1:0] eid,
        input logic                    mv, input logic [REG_ID_WIDTH-1:0] mid,
        input logic                    wv, input logic [REG_ID_WIDTH-1:0] wid
    );
        logic [1:0] s;
        s = 2'd0;
        if (rid != '0) begin
            if (ev && eid == rid)      s = 2'd1;
            else if (mv && mid == rid) s = 2'd2;
            else if (wv && wid == rid) s = 2'd3;
        end
        return s;
    endfunction

    // The value is late when producer stage + consume stage does not exceed its ready stage.
    function automatic logic is_hazard(input logic [1:0] x, input logic [1:0] s, input logic [1:0] r);
        return (s != NEED_NONE) && (x != 2'd0) && (({1'b0, x} + {1'b0, s}) <= {1'b0, r});
    endfunction

    function automatic logic [1:0] rdy_of(input logic [1:0] x, input logic [1:0] er,
                                          input logic [1:0] mr, input logic [1:0] wr);
        logic [1:0] r;
        case (x)
            2'd1:    r = er;
            2'd2:    r = mr;
            2'd3:    r = wr;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        d_fwd1 = src_stage(d_read_id1, e_vld_q, e_id_q, m_vld_q, m_id_q, w_vld_q, w_id_q);
        d_fwd2 = src_stage(d_read_id2, e_vld_q, e_id_q, m_vld_q, m_id_q, w_vld_q, w_id_q);
        rdy1   = rdy_of(d_fwd1, e_rdy_q, m_rdy_q, w_rdy_q);
        rdy2   = rdy_of(d_fwd2, e_rdy_q, m_rdy_q, w_rdy_q);
        hz1    = is_hazard(d_fwd1, d_need_stage1, rdy1);
        hz2    = is_hazard(d_fwd2, d_need_stage2, rdy2);
        stall  = d_valid && (hz1 || hz2);
    end

    // Ready stage 3 behaves as M, folded in here so the stored value is never 3.
    assign d_rdy_norm = (d_ready_stage == 2'd3) ? 2'd2 : d_ready_stage;
    assign d_ent_vld  = d_valid && d_write_enabled && (d_write_id != '0);

    always_comb begin
        e_vld_d = d_ent_vld && !stall;
        e_id_d  = d_write_id;
        e_rdy_d = d_rdy_norm;
        cnt_d   = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            e_vld_q <= 1'b0;
            m_vld_q <= 1'b0;
            w_vld_q <= 1'b0;
            e_id_q  <= '0;
            m_id_q  <= '0;
            w_id_q  <= '0;
            e_rdy_q <= 2'd0;
            m_rdy_q <= 2'd0;
            w_rdy_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            w_vld_q <= m_vld_q;
            w_id_q  <= m_id_q;
            w_rdy_q <= m_rdy_q;
            m_vld_q <= e_vld_q;
            m_id_q  <= e_id_q;
            m_rdy_q <= e_rdy_q;
            e_vld_q <= e_vld_d;
            e_id_q  <= e_id_d;
            e_rdy_q <= e_rdy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed pipeline sequences with a scoreboard queue of expected outputs.
// Latency: one expectation per driven cycle, compared on the falling edge of the same cycle.
// Backpressure: the bench re-drives a stalled instruction itself; the stall counter is narrowed to exercise saturation.
module tb_hazard_tracker;

    localparam int RW  = 5;
    localparam int SCW = 3;

    logic           clock;
    logic           reset;
    logic           d_valid;
    logic [RW-1:0]  d_read_id1, d_read_id2, d_write_id;
    logic [1:0]     d_need_stage1, d_need_stage2, d_ready_stage;
    logic           d_write_enabled;
    logic           stall;
    logic [1:0]     d_fwd1, d_fwd2;
    logic [SCW-1:0] stall_count;

    hazard_tracker #(.REG_ID_WIDTH(RW), .STALL_COUNT_WIDTH(SCW)) dut (
        .clock          (clock),
        .reset          (reset),
        .d_valid        (d_valid),
        .d_read_id1     (d_read_id1),
        .d_read_id2     (d_read_id2),
        .d_need_stage1  (d_need_stage1),
        .d_need_stage2  (d_need_stage2),
        .d_write_enabled(d_write_enabled),
        .d_write_id     (d_write_id),
        .d_ready_stage  (d_ready_stage),
        .stall          (stall),
        .d_fwd1         (d_fwd1),
        .d_fwd2         (d_fwd2),
        .stall_count    (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic           stall;
        logic [1:0]     f1;
        logic [1:0]     f2;
        logic [SCW-1:0] cnt;
    } exp_t;

    exp_t           exp_q[$];
    logic [SCW-1:0] exp_cnt = '0;
    int             n_vec   = 0;
    int             n_err   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall", 32'(stall), 32'(e.stall));
            check("d_fwd1", 32'(d_fwd1), 32'(e.f1));
            check("d_fwd2", 32'(d_fwd2), 32'(e.f2));
            check("stall_count", 32'(stall_count), 32'(e.cnt));
        end
    end

    // Drive one D-stage cycle and queue what the outputs must be during it.
    task automatic drv(input logic r, input logic v,
                       input int r1, input int s1, input int r2, input int s2,
                       input logic we, input int wid, input int rdy,
                       input logic es, input int ef1, input int ef2);
        exp_t e;
        @(posedge clock);
        #1;
        reset           = r;
        d_valid         = v;
        d_read_id1      = RW'(r1);
        d_need_stage1   = 2'(s1);
        d_read_id2      = RW'(r2);
        d_need_stage2   = 2'(s2);
        d_write_enabled = we;
        d_write_id      = RW'(wid);
        d_ready_stage   = 2'(rdy);
        e.stall = es;
        e.f1    = 2'(ef1);
        e.f2    = 2'(ef2);
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        if (r)                           exp_cnt = '0;
        else if (es && (exp_cnt != '1))  exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; d_valid = 1'b0; d_read_id1 = '0; d_read_id2 = '0;
        d_need_stage1 = 2'd3; d_need_stage2 = 2'd3; d_write_enabled = 1'b0;
        d_write_id = '0; d_ready_stage = 2'd0;

        // Reset state
        drv(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
        nops(1);

        // ALU result consumed in E: forwarded from E/M, no stall
        drv(0, 1, 0, 3, 0, 3, 1, 3, 1, 0, 0, 0);
        drv(0, 1, 3, 1, 0, 3, 1, 8, 1, 0, 1, 0);
        nops(3);

        // Load-use at EXECUTION: one stall, then M/W forward
        drv(0, 1, 0, 3, 0, 3, 1, 4, 2, 0, 0, 0);
        drv(0, 1, 4, 1, 9, 1, 1, 10, 1, 1, 1, 0);
        drv(0, 1, 4, 1, 9, 1, 1, 10, 1, 0, 2, 0);
        nops(3);

        // Branch after ALU: one stall
        drv(0, 1, 0, 3, 0, 3, 1, 5, 1, 0, 0, 0);
        drv(0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        drv(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        nops(3);

        // Branch after load, both operands: two stalls counted once per cycle
        drv(0, 1, 0, 3, 0, 3, 1, 6, 2, 0, 0, 0);
        drv(0, 1, 6, 0, 6, 0, 0, 0, 0, 1, 1, 1);
        drv(0, 1, 6, 0, 6, 0, 0, 0, 0, 1, 2, 2);
        drv(0, 1, 6, 0, 6, 0, 0, 0, 0, 0, 3, 3);
        nops(3);

        // Load with ready stage 3 (acts as M), consumer at MEMORY: no stall
        drv(0, 1, 0, 3, 0, 3, 1, 12, 3, 0, 0, 0);
        drv(0, 1, 12, 2, 0, 3, 0, 0, 0, 0, 1, 0);
        nops(3);

        // Write to $0 never forwards or stalls
        drv(0, 1, 0, 3, 0, 3, 1, 0, 2, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nops(3);

        // $7 written in both M and E: E wins
        drv(0, 1, 0, 3, 0, 3, 1, 7, 1, 0, 0, 0);
        drv(0, 1, 0, 3, 0, 3, 1, 7, 1, 0, 0, 0);
        drv(0, 1, 7, 1, 7, 1, 0, 0, 0, 0, 1, 1);
        nops(3);

        // d_valid=0 suppresses stall but still reports forwarding; W never stalls
        drv(0, 1, 0, 3, 0, 3, 1, 11, 2, 0, 0, 0);
        drv(0, 0, 11, 0, 0, 3, 0, 0, 0, 0, 1, 0);
        drv(0, 1, 11, 0, 0, 3, 0, 0, 0, 1, 2, 0);
        drv(0, 1, 11, 0, 0, 3, 0, 0, 0, 0, 3, 0);
        nops(3);

        // Repeated load-use to push the narrow counter into saturation
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 0, 3, 0, 3, 1, 4, 2, 0, 0, 0);
            drv(0, 1, 0, 3, 4, 1, 0, 0, 0, 1, 0, 1);
            drv(0, 1, 0, 3, 4, 1, 0, 0, 0, 0, 0, 2);
            nops(3);
        end

        // Reset during a load-use stall releases the consumer next cycle
        drv(0, 1, 0, 3, 0, 3, 1, 4, 2, 0, 0, 0);
        drv(1, 1, 4, 1, 0, 3, 1, 10, 1, 1, 1, 0);
        drv(0, 1, 4, 1, 0, 3, 1, 10, 1, 0, 0, 0);
        nops(3);
        drv(0, 1, 0, 3, 0, 3, 1, 4, 2, 0, 0, 0);
        drv(0, 1, 4, 1, 0, 3, 1, 10, 1, 1, 1, 0);
        drv(0, 1, 4, 1, 0, 3, 1, 10, 1, 0, 2, 0);
        nops(2);

        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
